// File: rtl/assert_event_scheduler.sv
// -----------------------------------------------------------------------------
// assert_event_scheduler
//
// Central collector for per-site assertion monitors. Each monitor raises one
// fire bit when its check fails. Fires are latched into a pending vector. A
// round-robin arbiter moves pending sources into a small report FIFO, which a
// single reporter drains over a valid/ready handshake. After the first failure
// a countdown window opens. Once that window has expired and nothing is pending
// or queued, a sticky stop request is raised.
//
// Optional feature macro: ASSERT_SCHED_TIMESTAMP_EN
//   defined   : a free-running TS_W cycle counter runs from reset. Each FIFO
//               entry also carries the counter value from its grant cycle.
//               The rpt_time_o port is present.
//   undefined : no counter. Entries hold the source index only. The
//               rpt_time_o port is absent.
//
// Ports
//   clock_i      in   1        single clock, all logic on posedge
//   reset_n_i    in   1        synchronous reset, active-low
//   fire_i       in   NUM_SRC  per-source failure level, sampled every clock
//   mask_i       in   NUM_SRC  1 = ignore source (pending bits are kept)
//   rpt_valid_o  out  1        FIFO head valid
//   rpt_ready_i  in   1        reporter accepts head
//   rpt_src_o    out  SRC_W    source index of head entry (0 when empty)
//   rpt_time_o   out  TS_W     grant timestamp of head (macro builds only)
//   drop_cnt_o   out  8        saturating count of merged/lost fires
//   stop_req_o   out  1        sticky request to end simulation
//   busy_o       out  1        something pending or queued
// -----------------------------------------------------------------------------
module assert_event_scheduler #(
  parameter int NUM_SRC    = 8,
  parameter int DEPTH      = 4,
  parameter int STOP_DELAY = 16,
  parameter int TS_W       = 32,
  localparam int SRC_W     = $clog2(NUM_SRC)
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic [NUM_SRC-1:0] fire_i,
  input  logic [NUM_SRC-1:0] mask_i,
  output logic               rpt_valid_o,
  input  logic               rpt_ready_i,
  output logic [SRC_W-1:0]   rpt_src_o,
`ifdef ASSERT_SCHED_TIMESTAMP_EN
  output logic [TS_W-1:0]    rpt_time_o,
`endif
  output logic [7:0]         drop_cnt_o,
  output logic               stop_req_o,
  output logic               busy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = (STOP_DELAY > 0) ? $clog2(STOP_DELAY + 1) : 1;
  localparam int MC_W  = SRC_W + 1;
  localparam int DS_W  = SRC_W + 9;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_STOP  = 2'd2;

  // Reject configurations the pointer arithmetic cannot handle.
  generate
    if (NUM_SRC < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        STOP_DELAY < 0 || TS_W < 1) begin : g_cfg_check
      $error("assert_event_scheduler: illegal parameter set");
    end
  endgenerate

  logic [NUM_SRC-1:0] fire_eff;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] grant_oh, merge_vec;
  logic               grant_valid;
  logic [SRC_W-1:0]   grant_idx, cand_idx;
  logic [SRC_W-1:0]   rr_q, rr_d;
  logic [MC_W-1:0]    merge_cnt;
  logic [DS_W-1:0]    drop_sum;
  logic [7:0]         drop_cnt_q, drop_cnt_d;

  logic [SRC_W-1:0]   src_mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q;
  logic               fifo_full, fifo_empty, push, pop, drained;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  assign fire_eff   = fire_i & ~mask_i;
  assign fifo_full  = (count_q == (PTR_W + 1)'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign drained    = (pending_q == '0) && fifo_empty;

  // Round-robin search starting at rr_q. Full is the registered count, so a
  // pop in the same cycle does not free a slot for this cycle's grant.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand_idx = SRC_W'((int'(rr_q) + k) % NUM_SRC);
      if (!grant_valid && !fifo_full && pending_q[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign grant_oh = grant_valid ? (NUM_SRC'(1) << grant_idx) : '0;
  assign rr_d     = (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + SRC_W'(1);

  // A new fire always sets the bit, so a fire on the granted source produces a
  // second report. A fire on an already-pending, ungranted source is merged.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign pending_d[gi] = fire_eff[gi] | (pending_q[gi] & ~grant_oh[gi]);
      assign merge_vec[gi] = fire_eff[gi] & pending_q[gi] & ~grant_oh[gi];
    end
  endgenerate

  always_comb begin
    merge_cnt = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      merge_cnt = merge_cnt + MC_W'(merge_vec[k]);
    end
    drop_sum   = DS_W'(drop_cnt_q) + DS_W'(merge_cnt);
    drop_cnt_d = (drop_sum > DS_W'(255)) ? 8'hFF : drop_sum[7:0];
  end

  assign push = grant_valid;
  assign pop  = rpt_valid_o & rpt_ready_i;

  // Stop sequencer: only the arming decision looks at the mask.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (fire_eff != '0) begin
          state_d = ST_ARMED;
          cnt_d   = CNT_W'(STOP_DELAY);
        end
      end
      ST_ARMED: begin
        if (cnt_q == '0) begin
          if (drained) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STOP: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      pending_q  <= '0;
      rr_q       <= '0;
      drop_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
    end else begin
      pending_q  <= pending_d;
      drop_cnt_q <= drop_cnt_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      if (grant_valid) rr_q <= rr_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset. The head outputs are gated by valid instead.
  always_ff @(posedge clock_i) begin
    if (push) src_mem_q[wr_ptr_q] <= grant_idx;
  end

  assign rpt_valid_o = ~fifo_empty;
  assign rpt_src_o   = rpt_valid_o ? src_mem_q[rd_ptr_q] : '0;
  assign drop_cnt_o  = drop_cnt_q;
  assign busy_o      = (pending_q != '0) | ~fifo_empty;
  // Raised in the last ARMED cycle too, so stop appears as soon as the window
  // has expired and everything is drained.
  assign stop_req_o  = (state_q == ST_STOP) ||
                       ((state_q == ST_ARMED) && (cnt_q == '0) && drained);

`ifdef ASSERT_SCHED_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] time_mem_q [DEPTH];

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) ts_q <= '0;
    else            ts_q <= ts_q + TS_W'(1);
  end

  always_ff @(posedge clock_i) begin
    if (push) time_mem_q[wr_ptr_q] <= ts_q;
  end

  assign rpt_time_o = rpt_valid_o ? time_mem_q[rd_ptr_q] : '0;
`endif

endmodule

// File: tb/tb_assert_event_scheduler.sv
module tb_assert_event_scheduler;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int SD = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] fire = '0;
  logic [N-1:0] mask = '0;
  logic         rpt_ready = 1'b1;
  logic         rpt_valid;
  logic [1:0]   rpt_src;
  logic [7:0]   drop_cnt;
  logic         stop_req;
  logic         busy;
`ifdef ASSERT_SCHED_TIMESTAMP_EN
  logic [31:0]  rpt_time;
`endif

  always #5 clk = ~clk;

  assert_event_scheduler #(.NUM_SRC(N), .DEPTH(D), .STOP_DELAY(SD), .TS_W(32)) dut (
    .clock_i     (clk),
    .reset_n_i   (reset_n),
    .fire_i      (fire),
    .mask_i      (mask),
    .rpt_valid_o (rpt_valid),
    .rpt_ready_i (rpt_ready),
    .rpt_src_o   (rpt_src),
`ifdef ASSERT_SCHED_TIMESTAMP_EN
    .rpt_time_o  (rpt_time),
`endif
    .drop_cnt_o  (drop_cnt),
    .stop_req_o  (stop_req),
    .busy_o      (busy)
  );

  // ---------------- reference model ----------------
  typedef struct { int src; int ts; } ent_t;
  bit   m_pend [N];
  ent_t m_q [$];
  int   m_rr, m_drop, m_cnt, m_ts;
  bit   m_armed, m_stopped;
  int   cyc;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic bit m_any();
    bit a = 0;
    for (int i = 0; i < N; i++) a |= m_pend[i];
    return a;
  endfunction

  function automatic bit m_stop();
    return m_stopped || (m_armed && m_cnt == 0 && !m_any() && m_q.size() == 0);
  endfunction

  function automatic bit m_busy();
    return m_any() || (m_q.size() > 0);
  endfunction

  task automatic model_update();
    bit eff [N];
    bit any_eff;
    int g;
    if (!reset_n) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_q.delete();
      m_rr = 0; m_drop = 0; m_cnt = 0; m_ts = 0;
      m_armed = 0; m_stopped = 0;
      return;
    end
    any_eff = 0;
    for (int i = 0; i < N; i++) begin
      eff[i]  = fire[i] && !mask[i];
      any_eff |= eff[i];
    end
    if (!m_stopped) begin
      if (m_armed) begin
        if (m_cnt == 0) begin
          if (!m_any() && m_q.size() == 0) m_stopped = 1;
        end else m_cnt--;
      end else if (any_eff) begin
        m_armed = 1;
        m_cnt   = SD;
      end
    end
    g = -1;
    if (m_q.size() < D)
      for (int k = 0; k < N; k++)
        if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
    for (int i = 0; i < N; i++)
      if (eff[i] && m_pend[i] && i != g && m_drop < 255) m_drop++;
    if (m_q.size() > 0 && rpt_ready) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back('{g, m_ts});
      m_pend[g] = 0;
      m_rr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) if (eff[i]) m_pend[i] = 1;
    m_ts++;
  endtask

  // One clock: model follows the edge, outputs are then sampled at negedge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset_n = 0; fire = '0; mask = '0; rpt_ready = 1;
    step();
    reset_n = 1;
    cyc = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    fire = 4'b1011;
    step(); step();
    do_reset();
    n_tests++; if (rpt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", rpt_valid); end
    n_tests++; if (rpt_src !== 2'd0) begin n_fail++; $display("FAIL reset_src got=%0d exp=0", rpt_src); end
    n_tests++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    n_tests++; if (stop_req !== 1'b0) begin n_fail++; $display("FAIL reset_stop got=%0b exp=0", stop_req); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
`ifdef ASSERT_SCHED_TIMESTAMP_EN
    n_tests++; if (rpt_time !== 32'd0) begin n_fail++; $display("FAIL reset_time got=%0d exp=0", rpt_time); end
`endif
  endtask

  task automatic test_single_fire();
    do_reset();
    while (cyc < 10) step();
    fire = 4'b0100;
    step();
    fire = '0;
    while (cyc <= 21) begin
      n_tests++;
      if (rpt_valid !== (cyc == 12)) begin n_fail++; $display("FAIL single_valid cyc=%0d got=%0b exp=%0b", cyc, rpt_valid, cyc == 12); end
      if (cyc == 12) begin
        $display("[TB] single: report src=%0d at cycle %0d", rpt_src, cyc);
        n_tests++; if (rpt_src !== 2'd2) begin n_fail++; $display("FAIL single_src got=%0d exp=2", rpt_src); end
      end
      n_tests++;
      if (stop_req !== (cyc >= 19)) begin n_fail++; $display("FAIL single_stop cyc=%0d got=%0b exp=%0b", cyc, stop_req, cyc >= 19); end
      step();
    end
  endtask

  task automatic test_all_fire();
    do_reset();
    while (cyc < 10) step();
    fire = 4'b1111;
    step();
    fire = '0;
    while (cyc <= 16) begin
      n_tests++;
      if (rpt_valid !== (cyc >= 12 && cyc <= 15)) begin n_fail++; $display("FAIL allfire_valid cyc=%0d got=%0b", cyc, rpt_valid); end
      if (cyc >= 12 && cyc <= 15) begin
        $display("[TB] allfire: report src=%0d at cycle %0d", rpt_src, cyc);
        n_tests++;
        if (rpt_src !== 2'(cyc - 12)) begin n_fail++; $display("FAIL allfire_src cyc=%0d got=%0d exp=%0d", cyc, rpt_src, cyc - 12); end
      end
      step();
    end
    n_tests++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL allfire_drop got=%0d exp=0", drop_cnt); end
  endtask

  task automatic test_backpressure();
    int got [$];
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    do_reset();
    rpt_ready = 0;
    while (cyc < 10) step();
    fire = 4'b1111;
    step();
    fire = 4'b0001;
    repeat (6) step();
    fire = '0;
    while (cyc < 25) begin
      n_tests++; if (stop_req !== 1'b0) begin n_fail++; $display("FAIL bp_stop_early cyc=%0d got=%0b exp=0", cyc, stop_req); end
      step();
    end
    n_tests++; if (drop_cnt !== 8'd5) begin n_fail++; $display("FAIL bp_drop got=%0d exp=5", drop_cnt); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy got=%0b exp=1", busy); end
    n_tests++; if (rpt_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got=%0b exp=1", rpt_valid); end
    rpt_ready = 1;
    for (int b = 0; b < 12 && rpt_valid === 1'b1; b++) begin
      $display("[TB] backpressure: report src=%0d at cycle %0d", rpt_src, cyc);
      got.push_back(int'(rpt_src));
      n_tests++; if (stop_req !== 1'b0) begin n_fail++; $display("FAIL bp_stop_draining cyc=%0d got=%0b exp=0", cyc, stop_req); end
      step();
    end
    n_tests++;
    if (got.size() != 5) begin n_fail++; $display("FAIL bp_count got=%0d exp=5", got.size()); end
    for (int i = 0; i < got.size() && i < 5; i++) begin
      n_tests++;
      if (got[i] != exp_seq[i]) begin n_fail++; $display("FAIL bp_src idx=%0d got=%0d exp=%0d", i, got[i], exp_seq[i]); end
    end
    n_tests++; if (stop_req !== 1'b1) begin n_fail++; $display("FAIL bp_stop_final got=%0b exp=1", stop_req); end
  endtask

  task automatic test_mask();
    do_reset();
    mask = 4'b0100;
    while (cyc < 10) step();
    fire = 4'b0100;
    step();
    fire = '0;
    while (cyc <= 25) begin
      n_tests++;
      if (rpt_valid !== 1'b0 || busy !== 1'b0 || stop_req !== 1'b0) begin
        n_fail++; $display("FAIL mask_quiet cyc=%0d valid=%0b busy=%0b stop=%0b exp=000", cyc, rpt_valid, busy, stop_req);
      end
      step();
    end
    mask = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    rpt_ready = 0;
    fire = 4'b0111;
    step();
    fire = 4'b0001;
    repeat (3) step();
    fire = '0;
    step();
    n_tests++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL mid_drop_pre got=%0d exp=2", drop_cnt); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_pre got=%0b exp=1", busy); end
    reset_n = 0;
    step();
    reset_n = 1;
    n_tests++; if (rpt_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got=%0b exp=0", rpt_valid); end
    n_tests++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_drop got=%0d exp=0", drop_cnt); end
    n_tests++; if (stop_req !== 1'b0) begin n_fail++; $display("FAIL mid_stop got=%0b exp=0", stop_req); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got=%0b exp=0", busy); end
    rpt_ready = 1;
  endtask

`ifdef ASSERT_SCHED_TIMESTAMP_EN
  task automatic test_timestamp();
    do_reset();
    while (cyc < 10) step();
    fire = 4'b0010;
    step();
    fire = '0;
    step();
    n_tests++; if (rpt_valid !== 1'b1) begin n_fail++; $display("FAIL ts_valid got=%0b exp=1", rpt_valid); end
    n_tests++; if (rpt_time !== 32'd11) begin n_fail++; $display("FAIL ts_time got=%0d exp=11", rpt_time); end
    $display("[TB] timestamp: report src=%0d time=%0d", rpt_src, rpt_time);
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        fire[i] = ($urandom_range(0, 5) == 0);
        mask[i] = ($urandom_range(0, 7) == 0);
      end
      rpt_ready = ($urandom_range(0, 9) < 7);
      reset_n   = ($urandom_range(0, 499) != 0);
      step();
      n_tests++;
      if (rpt_valid !== (m_q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, rpt_valid, m_q.size() > 0); end
      if (m_q.size() > 0) begin
        n_tests++;
        if (rpt_src !== 2'(m_q[0].src)) begin n_fail++; $display("FAIL rnd_src c=%0d got=%0d exp=%0d", c, rpt_src, m_q[0].src); end
`ifdef ASSERT_SCHED_TIMESTAMP_EN
        n_tests++;
        if (rpt_time !== 32'(m_q[0].ts)) begin n_fail++; $display("FAIL rnd_time c=%0d got=%0d exp=%0d", c, rpt_time, m_q[0].ts); end
`endif
      end
      n_tests++;
      if (drop_cnt !== 8'(m_drop)) begin n_fail++; $display("FAIL rnd_drop c=%0d got=%0d exp=%0d", c, drop_cnt, m_drop); end
      n_tests++;
      if (stop_req !== m_stop()) begin n_fail++; $display("FAIL rnd_stop c=%0d got=%0b exp=%0b", c, stop_req, m_stop()); end
      n_tests++;
      if (busy !== m_busy()) begin n_fail++; $display("FAIL rnd_busy c=%0d got=%0b exp=%0b", c, busy, m_busy()); end
    end
    reset_n = 1; fire = '0; mask = '0; rpt_ready = 1;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_fire();
    test_all_fire();
    test_backpressure();
    test_mask();
    test_reset_mid();
`ifdef ASSERT_SCHED_TIMESTAMP_EN
    test_timestamp();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
